alu_arbiter: RTL
================

# alu_arbiter

Sequencer and two-port arbiter for the shared 32-bit gate-level ALU (`alu`). It accepts operations from two requesters over valid/ready handshakes and grants them round-robin. It holds the granted operands on the ALU inputs for a fixed settle window, since the ALU's ripple of #1 gates needs several cycles, then captures a tagged, registered response. It also adds set-less-than on top of the ALU's add/sub path and computes a correct signed-overflow flag.

## Interface
Parameters:
- SETTLE, 2, clock cycles the ALU inputs are held stable before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1  requester has an operation.
- req0_ready, req1_ready  out  1  arbiter accepts the operation this cycle.
- req0_a, req0_b, req1_a, req1_b  in  32  operands.
- req0_op, req1_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes are illegal.
- alu_a, alu_b  out  32  registered operands to the ALU.
- alu_op  out  3  registered ALU op code.
- alu_result  in  32  ALU result.
- alu_cout, alu_zero, alu_set  in  1  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  32  result.
- rsp_cout, rsp_zero, rsp_ovf, rsp_err  out  1  response flags.

## Operation
- FSM states are IDLE, BUSY and RESP.
- Arbitration is combinational in IDLE only. `last` holds the last-granted index.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester other than `last` is granted.
  - reqN_ready = (state==IDLE) && grant==N. Both ready outputs are 0 outside IDLE.
- Accept occurs on an edge with valid && ready. On accept:
  - Register a, b, op and id; set last=id.
  - Load cnt=SETTLE and go to BUSY.
- ALU drive:
  - alu_a and alu_b are the registered operands.
  - alu_op = 110 for SLT. For any other legal op it is the registered op. For an illegal op it is 000.
  - The ALU inputs stay constant from accept until the next accept.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - Capture the response fields and go to RESP.
  - Set rsp_valid=1.
- Response fields:
  - ADD/SUB: rsp_result=alu_result, rsp_cout=alu_cout, rsp_zero=alu_zero.
  - rsp_ovf = (a31 == b'31) && (r31 != a31), where b' = b for ADD and ~b for SUB. It is computed locally; alu_overflow is not used.
  - AND/OR: rsp_result=alu_result, rsp_zero=(alu_result==0), rsp_cout=0, rsp_ovf=0.
  - SLT: rsp_result={31'b0, alu_set ^ ovf_sub}, rsp_zero=(rsp_result==0), rsp_cout=alu_cout, rsp_ovf=0.
  - Illegal op: rsp_result=0, rsp_zero=1, rsp_cout=0, rsp_ovf=0, rsp_err=1. For legal ops rsp_err=0.
- RESP: all rsp_* outputs are held stable while rsp_valid && !rsp_ready. The edge with rsp_ready=1 clears rsp_valid and returns to IDLE.
- No new request is accepted on the same edge as the response handshake.
- A requester whose valid drops before it is granted is simply not served. There is no request queueing.

## Timing
- Reset, asynchronous:
  - state=IDLE, cnt=0, last=1, so req0 wins the first tie.
  - rsp_valid=0, rsp_id=0, rsp_result=0, and all rsp flags 0.
  - alu_a=0, alu_b=0, alu_op=000.
- Reset during BUSY or RESP aborts the operation. No response is produced and rsp_valid is 0 immediately.
- Latency: rsp_valid rises exactly SETTLE edges after the accept edge.
- Throughput: with rsp_ready tied high, one operation completes every SETTLE+2 cycles.
- All outputs except reqN_ready are registered.
- reqN_ready depends combinationally on state, req valids and last.
- Arithmetic is modulo 2^32. Flags are defined only from the 32-bit operands.

## Test plan
- req0 ADD a=5, b=7, SETTLE=2 -> rsp_valid 2 edges after accept; result=12, id=0, cout=0, zero=0, ovf=0, err=0.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1. SUB a=b=0x1234 -> result=0, zero=1, cout=1, ovf=0.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLT a=0x7FFFFFFF, b=0x80000000 -> result=0, the overflow-corrected case. Op 011 -> err=1, result=0.
- Both valids held high with rsp_ready=1 for 4 ops -> rsp_id sequence 0,1,0,1. alu_a/b/op stay constant through every BUSY window.
- rsp_ready held low for 5 cycles in RESP -> rsp_* stable and both readys 0; rsp_ready=1 -> IDLE on the next edge, next accept one cycle later.
- reset asserted mid-BUSY -> rsp_valid=0 and outputs at reset values; after release, simultaneous requests grant req0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin two-port sequencer for the shared ripple ALU,
//               holding operands for a settle window and returning a tagged
//               registered response with SLT and signed-overflow support.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_zero,
    input  logic        alu_set,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_busy   = 2'd1;
    localparam logic [1:0] c_resp   = 2'd2;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;

    localparam logic [3:0] c_settle = 4'(SETTLE);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic        r_id;
    logic [2:0]  r_alu_op;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_cout;
    logic        r_rsp_zero;
    logic        r_rsp_ovf;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] w_in_a;
    logic [31:0] w_in_b;
    logic [2:0]  w_in_op;
    logic [2:0]  w_map_op;
    logic        w_ovf_add;
    logic        w_ovf_sub;
    logic        w_slt_bit;
    logic [31:0] w_result;
    logic        w_cout;
    logic        w_zero;
    logic        w_ovf;
    logic        w_err;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle     = (r_state == c_idle);
    assign req0_ready = w_idle && !w_grant;
    assign req1_ready = w_idle && w_grant;
    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign w_in_a  = w_grant ? req1_a  : req0_a;
    assign w_in_b  = w_grant ? req1_b  : req0_b;
    assign w_in_op = w_grant ? req1_op : req0_op;

    always_comb begin
        w_map_op = c_op_and;
        case (w_in_op)
            c_op_and, c_op_or, c_op_add, c_op_sub: w_map_op = w_in_op;
            c_op_slt:                              w_map_op = c_op_sub;
            default:                               w_map_op = c_op_and;
        endcase
    end

    assign w_ovf_add = (r_a[31] == r_b[31])  && (alu_result[31] != r_a[31]);
    assign w_ovf_sub = (r_a[31] == ~r_b[31]) && (alu_result[31] != r_a[31]);
    // The raw sign of a-b is wrong exactly when the subtraction overflows.
    assign w_slt_bit = alu_set ^ w_ovf_sub;

    always_comb begin
        w_result = alu_result;
        w_cout   = 1'b0;
        w_zero   = (alu_result == 32'd0);
        w_ovf    = 1'b0;
        w_err    = 1'b0;
        case (r_op)
            c_op_add: begin
                w_cout = alu_cout;
                w_zero = alu_zero;
                w_ovf  = w_ovf_add;
            end
            c_op_sub: begin
                w_cout = alu_cout;
                w_zero = alu_zero;
                w_ovf  = w_ovf_sub;
            end
            c_op_and, c_op_or: begin
                w_result = alu_result;
            end
            c_op_slt: begin
                w_result = {31'd0, w_slt_bit};
                w_zero   = ~w_slt_bit;
                w_cout   = alu_cout;
            end
            default: begin
                w_result = 32'd0;
                w_zero   = 1'b1;
                w_err    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_idle;
            r_cnt        <= 4'd0;
            r_last       <= 1'b1;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_op         <= c_op_and;
            r_id         <= 1'b0;
            r_alu_op     <= c_op_and;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_cout   <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_a      <= w_in_a;
                        r_b      <= w_in_b;
                        r_op     <= w_in_op;
                        r_id     <= w_grant;
                        r_last   <= w_grant;
                        r_alu_op <= w_map_op;
                        r_cnt    <= c_settle;
                        r_state  <= c_busy;
                    end
                end
                c_busy: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_id;
                        r_rsp_result <= w_result;
                        r_rsp_cout   <= w_cout;
                        r_rsp_zero   <= w_zero;
                        r_rsp_ovf    <= w_ovf;
                        r_rsp_err    <= w_err;
                        r_state      <= c_resp;
                    end
                end
                c_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire
